// File: rtl/exec_seq_pkg.sv
// Shared definitions for the execute sequencer: FSM state encoding,
// exception cause codes, and the counter-width helper.
// No ports (package).
package exec_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_MEM   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_UNDEF = 2'b01;
  localparam logic [1:0] EXC_SWI   = 2'b10;
  localparam logic [1:0] EXC_ABORT = 2'b11;

  // One extra bit over the largest count so the load value never truncates.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/exec_sequencer_down_counter.sv
// seq_down_counter: loadable down counter that saturates at zero, shared by
// the multiply-wait and flush-hold phases of the sequencer.
// Ports: clk, rst (async, active-high), load/load_val, dec, value, zero.
module seq_down_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: issue/sequencing controller between decode and the execute
// units; fires ALU/multiplier/AHB, waits on multi-cycle units, strobes
// writeback, flushes on PC change and reports exception causes.
// Ports: clk, rst | decode handshake (dec_valid/dec_ready) + decoded fields |
//        ahb_done/ahb_err in | unit strobes, ahb_req/ahb_write, rf_wr_en,
//        pc_load/thumb_tgl, flush, exc_req/exc_type, busy out.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int MUL_CYCLES   = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  output logic       dec_ready,
  input  logic       cond_pass,
  input  logic       alu_en,
  input  logic       mul_en,
  input  logic       ahb_rd_en,
  input  logic       ahb_wr_en,
  input  logic       branch,
  input  logic       iset_switch,
  input  logic       swi,
  input  logic       undef,
  input  logic       ahb_done,
  input  logic       ahb_err,
  output logic       alu_fire,
  output logic       mul_start,
  output logic       ahb_req,
  output logic       ahb_write,
  output logic       rf_wr_en,
  output logic       pc_load,
  output logic       thumb_tgl,
  output logic       flush,
  output logic       exc_req,
  output logic [1:0] exc_type,
  output logic       busy
);

  localparam int CNT_W = cnt_width(MUL_CYCLES, FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  state_t           state;
  logic             br_latched;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  // Held low during reset so every output reads 0 while rst is asserted.
  assign dec_ready = (state == ST_IDLE) && !rst;
  assign accept    = dec_valid && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // Counter control mirrors the state transitions below: it loads in the same
  // edge that enters MUL or FLUSH, so the loaded value is visible on entry.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && cond_pass) begin
          if (undef || swi) begin
            cnt_load = 1'b1;
            cnt_val  = FLUSH_LOAD;
          end else if (ahb_rd_en || ahb_wr_en) begin
            cnt_load = 1'b0;
          end else if (mul_en) begin
            cnt_load = 1'b1;
            cnt_val  = MUL_LOAD;
          end else if (branch) begin
            cnt_load = 1'b1;
            cnt_val  = FLUSH_LOAD;
          end
        end
      end
      ST_MUL, ST_FLUSH: cnt_dec = 1'b1;
      ST_MEM: begin
        if (ahb_done && (ahb_err || (!ahb_write && br_latched))) begin
          cnt_load = 1'b1;
          cnt_val  = FLUSH_LOAD;
        end
      end
      default: cnt_dec = 1'b0;
    endcase
  end

  seq_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .value    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      br_latched <= 1'b0;
      alu_fire   <= 1'b0;
      mul_start  <= 1'b0;
      ahb_req    <= 1'b0;
      ahb_write  <= 1'b0;
      rf_wr_en   <= 1'b0;
      pc_load    <= 1'b0;
      thumb_tgl  <= 1'b0;
      flush      <= 1'b0;
      exc_req    <= 1'b0;
      exc_type   <= EXC_NONE;
    end else begin
      alu_fire  <= 1'b0;
      mul_start <= 1'b0;
      rf_wr_en  <= 1'b0;
      pc_load   <= 1'b0;
      thumb_tgl <= 1'b0;
      exc_req   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A failed condition retires the instruction with no side effects.
          if (accept && cond_pass) begin
            if (undef) begin
              exc_req  <= 1'b1;
              exc_type <= EXC_UNDEF;
              pc_load  <= 1'b1;
              state    <= ST_FLUSH;
            end else if (swi) begin
              exc_req  <= 1'b1;
              exc_type <= EXC_SWI;
              pc_load  <= 1'b1;
              state    <= ST_FLUSH;
            end else if (ahb_rd_en || ahb_wr_en) begin
              ahb_req    <= 1'b1;
              ahb_write  <= ahb_wr_en;
              br_latched <= branch;
              state      <= ST_MEM;
            end else if (mul_en) begin
              mul_start <= 1'b1;
              state     <= ST_MUL;
            end else begin
              if (alu_en) begin
                alu_fire <= 1'b1;
                rf_wr_en <= 1'b1;
              end
              if (branch) begin
                pc_load   <= 1'b1;
                thumb_tgl <= iset_switch;
                state     <= ST_FLUSH;
              end
            end
          end
        end
        ST_MUL: begin
          // Writeback is raised on the decrement that reaches zero so it lands
          // in the last MUL cycle; a one-cycle multiply has no such decrement.
          if (cnt_zero) begin
            state <= ST_IDLE;
            if (MUL_CYCLES == 1) rf_wr_en <= 1'b1;
          end else if (cnt_value == CNT_W'(1)) begin
            rf_wr_en <= 1'b1;
          end
        end
        ST_MEM: begin
          if (ahb_done) begin
            ahb_req   <= 1'b0;
            ahb_write <= 1'b0;
            if (ahb_err) begin
              exc_req  <= 1'b1;
              exc_type <= EXC_ABORT;
              pc_load  <= 1'b1;
              state    <= ST_FLUSH;
            end else if (!ahb_write) begin
              rf_wr_en <= 1'b1;
              if (br_latched) begin
                pc_load <= 1'b1;
                state   <= ST_FLUSH;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          // The entry cycle carries pc_load; flush follows for the loaded count.
          flush <= !cnt_zero;
          if (cnt_zero) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dec_valid, dec_ready, cond_pass, alu_en, mul_en, ahb_rd_en, ahb_wr_en;
  logic       branch, iset_switch, swi, undef, ahb_done, ahb_err;
  logic       alu_fire, mul_start, ahb_req, ahb_write, rf_wr_en, pc_load, thumb_tgl;
  logic       flush, exc_req, busy;
  logic [1:0] exc_type;

  exec_sequencer #(.MUL_CYCLES(3), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .cond_pass(cond_pass), .alu_en(alu_en), .mul_en(mul_en),
    .ahb_rd_en(ahb_rd_en), .ahb_wr_en(ahb_wr_en), .branch(branch),
    .iset_switch(iset_switch), .swi(swi), .undef(undef),
    .ahb_done(ahb_done), .ahb_err(ahb_err), .alu_fire(alu_fire),
    .mul_start(mul_start), .ahb_req(ahb_req), .ahb_write(ahb_write),
    .rf_wr_en(rf_wr_en), .pc_load(pc_load), .thumb_tgl(thumb_tgl),
    .flush(flush), .exc_req(exc_req), .exc_type(exc_type), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction field bits: {cond, alu, mul, rd, wr, br, isw, swi, undef}
  localparam logic [8:0] C  = 9'h100, A  = 9'h080, M  = 9'h040, RD = 9'h020;
  localparam logic [8:0] WR = 9'h010, BR = 9'h008, IS = 9'h004, SW = 9'h002, UD = 9'h001;
  // Strobe vector bits: {alu_fire, mul_start, rf_wr_en, pc_load, thumb_tgl, exc_req}
  localparam logic [5:0] S_ALU = 6'b100000, S_MUL = 6'b010000, S_RF = 6'b001000;
  localparam logic [5:0] S_PC  = 6'b000100, S_TT  = 6'b000010, S_EX = 6'b000001;

  typedef struct { int cyc; logic [5:0] s; logic [1:0] t; } sexp_t;
  typedef struct { int cyc; logic [4:0] l; } lexp_t;
  sexp_t sq[$];
  lexp_t lq[$];

  int         total = 0;
  int         bad = 0;
  logic [1:0] m_exc = 2'b00;
  bit         mon_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic es(input int c, input logic [5:0] s);
    sexp_t e;
    e.cyc = c; e.s = s; e.t = m_exc;
    sq.push_back(e);
  endtask

  // Level expectation: {ahb_req, ahb_write, flush, dec_ready, busy}
  task automatic el(input int c, input logic req, input logic wr, input logic fl, input logic rdy);
    lexp_t e;
    e.cyc = c; e.l = {req, wr, fl, rdy, ~rdy};
    lq.push_back(e);
  endtask

  task automatic drive(input logic [8:0] f);
    dec_valid = 1'b1;
    {cond_pass, alu_en, mul_en, ahb_rd_en, ahb_wr_en, branch, iset_switch, swi, undef} = f;
  endtask

  task automatic idle_in();
    dec_valid = 1'b0;
    {cond_pass, alu_en, mul_en, ahb_rd_en, ahb_wr_en, branch, iset_switch, swi, undef} = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [8:0] f);
    drive(f);
    tick(1);
    idle_in();
  endtask

  task automatic done(input logic err);
    ahb_done = 1'b1;
    ahb_err  = err;
    tick(1);
    ahb_done = 1'b0;
    ahb_err  = 1'b0;
  endtask

  // Monitor: pops expectations as the DUT presents strobes / at expected cycles.
  always @(negedge clk) begin : mon_blk
    sexp_t      e;
    logic [5:0] s;
    if (mon_on && !rst) begin
      s = {alu_fire, mul_start, rf_wr_en, pc_load, thumb_tgl, exc_req};
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        chk("strobe_missing_cycle", 64'(cyc), 64'(sq[0].cyc));
        void'(sq.pop_front());
      end
      if (s != 6'b0) begin
        if (sq.size() == 0) begin
          chk("strobe_unexpected", 64'(s), 64'(0));
        end else begin
          e = sq.pop_front();
          chk("strobe", {cyc, s, exc_type}, {e.cyc, e.s, e.t});
        end
      end
      while (lq.size() > 0 && lq[0].cyc < cyc) begin
        chk("level_missing_cycle", 64'(cyc), 64'(lq[0].cyc));
        void'(lq.pop_front());
      end
      if (lq.size() > 0 && lq[0].cyc == cyc) begin
        chk("level", {ahb_req, ahb_write, flush, dec_ready, busy}, lq[0].l);
        void'(lq.pop_front());
      end
    end
  end

  initial begin
    int c;
    idle_in();
    ahb_done = 1'b0;
    ahb_err  = 1'b0;
    rst = 1'b1;
    tick(2);
    chk("reset_outputs", {dec_ready, alu_fire, mul_start, ahb_req, ahb_write, rf_wr_en,
                          pc_load, thumb_tgl, flush, exc_req, exc_type, busy}, 64'(0));
    rst = 1'b0;
    tick(1);
    chk("ready_after_reset", {dec_ready, busy}, 64'b10);
    mon_on = 1'b1;

    // Back-to-back ALU ops: strobes every cycle, never busy.
    c = cyc;
    es(c+1, S_ALU|S_RF); es(c+2, S_ALU|S_RF); es(c+3, S_ALU|S_RF);
    el(c+1, 0,0,0,1); el(c+2, 0,0,0,1); el(c+3, 0,0,0,1);
    issue(C|A); issue(C|A); issue(C|A);

    // Multiply: start at t+1, writeback at t+3, not ready t+1..t+3.
    c = cyc;
    es(c+1, S_MUL); es(c+3, S_RF);
    el(c+1, 0,0,0,0); el(c+2, 0,0,0,0); el(c+3, 0,0,0,0); el(c+4, 0,0,0,1);
    issue(C|M); tick(3);

    // Load with done on the 4th request cycle.
    c = cyc;
    el(c+1, 1,0,0,0); el(c+2, 1,0,0,0); el(c+3, 1,0,0,0); el(c+4, 1,0,0,0);
    es(c+5, S_RF); el(c+5, 0,0,0,1);
    issue(C|RD); tick(3); done(1'b0);

    // Store: direction visible while held, no writeback.
    c = cyc;
    el(c+1, 1,1,0,0); el(c+2, 1,1,0,0); el(c+3, 0,0,0,1);
    issue(C|WR); tick(1); done(1'b0);

    // Load with bus error: abort, no writeback, then flush.
    c = cyc;
    m_exc = 2'b11;
    es(c+2, S_PC|S_EX);
    el(c+1, 1,0,0,0); el(c+2, 0,0,0,0); el(c+3, 0,0,1,0); el(c+4, 0,0,1,0); el(c+5, 0,0,0,1);
    issue(C|RD); done(1'b1); tick(3);

    // BX: pc_load and thumb_tgl together, decoder held valid during flush.
    c = cyc;
    es(c+1, S_ALU|S_RF|S_PC|S_TT);
    el(c+1, 0,0,0,0); el(c+2, 0,0,1,0); el(c+3, 0,0,1,0); el(c+4, 0,0,0,1);
    issue(C|A|BR|IS); drive(C|A); tick(3); idle_in();

    // undef and swi both set: undef wins.
    c = cyc;
    m_exc = 2'b01;
    es(c+1, S_PC|S_EX); el(c+4, 0,0,0,1);
    issue(C|SW|UD); tick(3);

    // swi alone.
    c = cyc;
    m_exc = 2'b10;
    es(c+1, S_PC|S_EX);
    issue(C|SW); tick(3);

    // Condition failed with swi/undef: retires silently.
    c = cyc;
    el(c+1, 0,0,0,1);
    issue(SW|UD);

    // Plain branch, no ISA switch.
    c = cyc;
    es(c+1, S_PC); el(c+2, 0,0,1,0); el(c+4, 0,0,0,1);
    issue(C|BR); tick(3);

    // Load that also writes PC: writeback plus pc_load, then flush.
    c = cyc;
    es(c+2, S_RF|S_PC); el(c+3, 0,0,1,0); el(c+5, 0,0,0,1);
    issue(C|RD|BR); done(1'b0); tick(3);

    // NOP.
    c = cyc;
    el(c+1, 0,0,0,1);
    issue(C);

    // Reset in the middle of a load.
    c = cyc;
    el(c+1, 1,0,0,0);
    issue(C|RD); tick(1);
    #2 rst = 1'b1;
    #1;
    chk("reset_mid_mem", {dec_ready, alu_fire, mul_start, ahb_req, ahb_write, rf_wr_en,
                          pc_load, thumb_tgl, flush, exc_req, exc_type, busy}, 64'(0));
    m_exc = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    c = cyc;
    el(c, 0,0,0,1); el(c+1, 0,0,0,1);
    done(1'b0);
    tick(4);

    chk("strobe_queue_drained", 64'(sq.size()), 64'(0));
    chk("level_queue_drained", 64'(lq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
